// File: rtl/outbox_if.sv
// Outbox bus: CPU write side, consumer handshake side and status flags.
// The DUT connects through the slave modport; the producer/consumer connects through master.
interface outbox_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
);
    logic              wOut;
    logic [DATA_W-1:0] data;
    logic              full;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_ready;
    logic [AW:0]       count;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        output wOut, data, o_ready, clr_ovf,
        input  full, o_data, o_valid, count, overflow
    );

    modport slave (
        input  wOut, data, o_ready, clr_ovf,
        output full, o_data, o_valid, count, overflow
    );
endinterface

// File: rtl/outbox.sv
// CPU-to-consumer outbox FIFO with a sticky overflow flag.
// The head word is read combinationally, and there is no bypass from write to read.
module outbox #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input logic     clk,
    input logic     rstn,
    outbox_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_e;

    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    occ_e              state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;
    logic [DATA_W-1:0] mem [DEPTH];

    // Full/empty are taken from the pre-edge state, so a pop never frees room for a same-edge push.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        push    = bus.wOut && (state_q != FULL);
        pop     = bus.o_ready && (state_q != EMPTY);
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        state_d = state_q;

        if (push) wp_d = wp_q + PTR_ONE;
        if (pop)  rp_d = rp_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new overflow event wins over a same-edge clear.
        if (bus.clr_ovf) ovf_d = 1'b0;
        if (bus.wOut && (state_q == FULL)) ovf_d = 1'b1;

        case (state_q)
            EMPTY: begin
                if (push) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && (count_q == CNT_MAX - CNT_ONE)) begin
                    state_d = FULL;
                end else if (pop && !push && (count_q == CNT_ONE)) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            state_q <= EMPTY;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (rstn && push) mem[wp_q] <= bus.data;
    end

    assign bus.o_data   = mem[rp_q];
    assign bus.o_valid  = (state_q != EMPTY);
    assign bus.full     = (state_q == FULL);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

    // The occupancy state and the word count must always describe the same occupancy.
    assert property (@(posedge clk) disable iff (!rstn)
        (count_q <= CNT_MAX) &&
        ((state_q == EMPTY) == (count_q == '0)) &&
        ((state_q == FULL)  == (count_q == CNT_MAX)));

endmodule
